// File: rtl/pc_seq_pkg.sv
// Shared encodings for the PC sequencer: ex_kind codes, FSM states and default reset PC.
package pc_seq_pkg;

  localparam logic [31:0] DefaultResetPc = 32'h0000_3000;

  localparam logic [1:0] KIND_SEQ = 2'd0;
  localparam logic [1:0] KIND_BR  = 2'd1;
  localparam logic [1:0] KIND_J   = 2'd2;
  localparam logic [1:0] KIND_JR  = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StExec,
    StHalt
  } state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch handshake, execute-resolution controls and status between sequencer and CPU.
interface pc_sequencer_if;

  logic [31:0] pc;
  logic        fetch_valid;
  logic        fetch_ready;
  logic        ex_valid;
  logic [1:0]  ex_kind;
  logic        br_taken;
  logic [15:0] br_offset;
  logic [25:0] j_index;
  logic [31:0] jr_target;
  logic        halt_req;
  logic        halted;
  logic        misalign;
  logic        redirect;

  modport master (
    output pc, fetch_valid, halted, misalign, redirect,
    input  fetch_ready, ex_valid, ex_kind, br_taken, br_offset, j_index, jr_target, halt_req
  );

  modport slave (
    input  pc, fetch_valid, halted, misalign, redirect,
    output fetch_ready, ex_valid, ex_kind, br_taken, br_offset, j_index, jr_target, halt_req
  );

endinterface

// File: rtl/pc_target_calc.sv
// Combinational next-PC selection for one resolved instruction.
module pc_target_calc
  import pc_seq_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  ex_kind,
  input  logic        br_taken,
  input  logic [15:0] br_offset,
  input  logic [25:0] j_index,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  logic [31:0] p4;
  logic [31:0] br_disp;

  assign p4      = pc + 32'd4;
  assign br_disp = {{14{br_offset[15]}}, br_offset, 2'b00};

  always_comb begin
    next_pc    = p4;
    misaligned = 1'b0;
    unique case (ex_kind)
      KIND_SEQ: next_pc = p4;
      KIND_BR:  next_pc = br_taken ? (p4 + br_disp) : p4;
      KIND_J:   next_pc = {p4[31:28], j_index, 2'b00};
      KIND_JR: begin
        // A misaligned target never reaches the PC; hold it instead.
        if (jr_target[1:0] != 2'b00) begin
          misaligned = 1'b1;
          next_pc    = pc;
        end else begin
          next_pc = jr_target;
        end
      end
      default: next_pc = p4;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: one fetch at a time, then redirect on the resolved instruction.
// Optional MIPS branch delay slot when DELAY_SLOT_EN is defined.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DefaultResetPc
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.master bus
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        misalign_q, misalign_d;
  logic        redirect_q, redirect_d;
  logic [31:0] next_pc;
  logic        tgt_misaligned;
  logic        nonseq;

`ifdef DELAY_SLOT_EN
  logic        pending_q, pending_d;
  logic [31:0] pending_pc_q, pending_pc_d;
`endif

  pc_target_calc u_target_calc (
    .pc         (pc_q),
    .ex_kind    (bus.ex_kind),
    .br_taken   (bus.br_taken),
    .br_offset  (bus.br_offset),
    .j_index    (bus.j_index),
    .jr_target  (bus.jr_target),
    .next_pc    (next_pc),
    .misaligned (tgt_misaligned)
  );

  assign nonseq = ((bus.ex_kind == KIND_BR) && bus.br_taken) ||
                  (bus.ex_kind == KIND_J) || (bus.ex_kind == KIND_JR);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = misalign_q;
    redirect_d = 1'b0;
`ifdef DELAY_SLOT_EN
    pending_d    = pending_q;
    pending_pc_d = pending_pc_q;
`endif
    unique case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: begin
        if (bus.fetch_ready) state_d = StExec;
      end
      StExec: begin
        if (bus.ex_valid) begin
          if (bus.halt_req) begin
            state_d = StHalt;
`ifdef DELAY_SLOT_EN
            pending_d = 1'b0;
`endif
`ifdef DELAY_SLOT_EN
          end else if (pending_q) begin
            // Delay-slot instruction resolved: its own kind is irrelevant.
            pc_d       = pending_pc_q;
            pending_d  = 1'b0;
            redirect_d = 1'b1;
            state_d    = StFetch;
`endif
          end else if (tgt_misaligned) begin
            misalign_d = 1'b1;
            state_d    = StHalt;
          end else if (nonseq) begin
`ifdef DELAY_SLOT_EN
            pending_pc_d = next_pc;
            pending_d    = 1'b1;
            pc_d         = pc_q + 32'd4;
`else
            pc_d       = next_pc;
            redirect_d = 1'b1;
`endif
            state_d = StFetch;
          end else begin
            pc_d    = next_pc;
            state_d = StFetch;
          end
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
      redirect_q <= 1'b0;
`ifdef DELAY_SLOT_EN
      pending_q    <= 1'b0;
      pending_pc_q <= RESET_PC;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      redirect_q <= redirect_d;
`ifdef DELAY_SLOT_EN
      pending_q    <= pending_d;
      pending_pc_q <= pending_pc_d;
`endif
    end
  end

  assign bus.pc          = pc_q;
  assign bus.fetch_valid = (state_q == StFetch);
  assign bus.halted      = (state_q == StHalt);
  assign bus.misalign    = misalign_q;
  assign bus.redirect    = redirect_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (default build, no delay slot) with a fetch-address scoreboard.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] exp_q[$];

  pc_sequencer_if bus ();

  pc_sequencer #(.RESET_PC(32'h0000_3000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a fetch request, compare its address with the scoreboard, accept it.
  task automatic fetch_accept(input string tag);
    int n = 0;
    logic [31:0] e;
    while (bus.fetch_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_fetch_valid"}, {31'd0, bus.fetch_valid}, 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_pc"}, bus.pc, e);
    end
    bus.fetch_ready = 1'b1;
    @(negedge clk);
    bus.fetch_ready = 1'b0;
    check({tag, "_exec"}, {31'd0, bus.fetch_valid}, 32'd0);
  endtask

  task automatic resolve(input logic [1:0] kind, input logic taken, input logic [15:0] off,
                         input logic [25:0] idx, input logic [31:0] jr, input logic halt);
    bus.ex_valid  = 1'b1;
    bus.ex_kind   = kind;
    bus.br_taken  = taken;
    bus.br_offset = off;
    bus.j_index   = idx;
    bus.jr_target = jr;
    bus.halt_req  = halt;
    @(negedge clk);
    bus.ex_valid = 1'b0;
    bus.halt_req = 1'b0;
    bus.br_taken = 1'b0;
  endtask

  initial begin
    bus.fetch_ready = 1'b0;
    bus.ex_valid    = 1'b0;
    bus.ex_kind     = KIND_SEQ;
    bus.br_taken    = 1'b0;
    bus.br_offset   = 16'h0;
    bus.j_index     = 26'h0;
    bus.jr_target   = 32'h0;
    bus.halt_req    = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_pc", bus.pc, 32'h0000_3000);
    check("rst_fetch_valid", {31'd0, bus.fetch_valid}, 32'd0);
    check("rst_halted", {31'd0, bus.halted}, 32'd0);
    check("rst_misalign", {31'd0, bus.misalign}, 32'd0);
    check("rst_redirect", {31'd0, bus.redirect}, 32'd0);
    rst = 1'b0;
    check("idle_no_fetch", {31'd0, bus.fetch_valid}, 32'd0);
    @(negedge clk);
    check("first_fetch", {31'd0, bus.fetch_valid}, 32'd1);

    // Sequential run 0x3000 .. 0x3010
    exp_q.push_back(32'h0000_3000);
    for (int i = 0; i < 4; i++) begin
      fetch_accept("seq");
      exp_q.push_back(32'h0000_3004 + 32'(i) * 32'd4);
      resolve(KIND_SEQ, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
      check("seq_redirect", {31'd0, bus.redirect}, 32'd0);
    end

    // Backward taken branch from 0x3010
    fetch_accept("br_src");
    exp_q.push_back(32'h0000_3004);
    resolve(KIND_BR, 1'b1, 16'hFFFC, 26'h0, 32'h0, 1'b0);
    check("br_redirect_hi", {31'd0, bus.redirect}, 32'd1);
    @(negedge clk);
    check("br_redirect_lo", {31'd0, bus.redirect}, 32'd0);

    // JR to 0x9000_0000, then J with index 0x400
    fetch_accept("br_dst");
    exp_q.push_back(32'h9000_0000);
    resolve(KIND_JR, 1'b0, 16'h0, 26'h0, 32'h9000_0000, 1'b0);
    check("jr_redirect", {31'd0, bus.redirect}, 32'd1);
    fetch_accept("jr_dst");
    exp_q.push_back(32'h9000_1000);
    resolve(KIND_J, 1'b0, 16'h0, 26'h000_0400, 32'h0, 1'b0);
    check("j_redirect", {31'd0, bus.redirect}, 32'd1);

    // Fetch stall with stray ex_valid; acceptance on the sixth cycle
    for (int i = 0; i < 5; i++) begin
      bus.ex_valid = 1'b1;
      bus.ex_kind  = KIND_J;
      bus.j_index  = 26'h3FF_FFFF;
      @(negedge clk);
      check("stall_pc", bus.pc, 32'h9000_1000);
      check("stall_fetch_valid", {31'd0, bus.fetch_valid}, 32'd1);
    end
    bus.ex_valid = 1'b0;
    fetch_accept("stall_accept");
    exp_q.push_back(32'h9000_1004);
    resolve(KIND_SEQ, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);

    // Misaligned JR halts with pc held
    fetch_accept("jr_src");
    resolve(KIND_JR, 1'b0, 16'h0, 26'h0, 32'h0040_0002, 1'b0);
    check("mis_flag", {31'd0, bus.misalign}, 32'd1);
    check("mis_halted", {31'd0, bus.halted}, 32'd1);
    check("mis_pc", bus.pc, 32'h9000_1004);
    repeat (3) @(negedge clk);
    check("mis_stays_halted", {31'd0, bus.halted}, 32'd1);
    check("mis_no_fetch", {31'd0, bus.fetch_valid}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("mis_rst_flag", {31'd0, bus.misalign}, 32'd0);
    check("mis_rst_halted", {31'd0, bus.halted}, 32'd0);
    check("mis_rst_pc", bus.pc, 32'h0000_3000);
    rst = 1'b0;

    // Reset during EXEC with a resolving J
    exp_q.push_back(32'h0000_3000);
    fetch_accept("rx_src");
    bus.ex_valid = 1'b1;
    bus.ex_kind  = KIND_J;
    bus.j_index  = 26'h000_0400;
    rst = 1'b1;
    @(negedge clk);
    check("rx_pc", bus.pc, 32'h0000_3000);
    check("rx_redirect", {31'd0, bus.redirect}, 32'd0);
    check("rx_fetch_valid", {31'd0, bus.fetch_valid}, 32'd0);
    rst = 1'b0;
    bus.ex_valid = 1'b0;

    // halt_req beats a taken branch
    exp_q.push_back(32'h0000_3000);
    fetch_accept("hb_src");
    resolve(KIND_BR, 1'b1, 16'h0010, 26'h0, 32'h0, 1'b1);
    check("hb_halted", {31'd0, bus.halted}, 32'd1);
    check("hb_pc", bus.pc, 32'h0000_3000);
    check("hb_redirect", {31'd0, bus.redirect}, 32'd0);
    @(negedge clk);
    check("hb_no_fetch", {31'd0, bus.fetch_valid}, 32'd0);
    check("hb_misalign", {31'd0, bus.misalign}, 32'd0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
